// File: rtl/robot_step_sequencer.sv
// Step controller for the pipe cleaner robot: sense, decide, act, settle, map.
// Optional pause-after-map parking is enabled with SEQ_PAUSE_EN.
module robot_step_sequencer #(
  parameter int unsigned MAX_STEPS     = 256,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_TURNS     = 4
) (
  input  logic        clock,
  input  logic        reset,
`ifdef SEQ_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        start,
  input  logic        head,
  input  logic        left,
  input  logic        under,
  input  logic        barreira,
  output logic        sense_en,
  output logic        orient_en,
  output logic        move_en,
  output logic        map_en,
  output logic        avancar,
  output logic        girar,
  output logic        remover,
  output logic        busy,
  output logic        done,
  output logic        stuck,
  output logic [15:0] step_count
);

  localparam logic [15:0] MAX_S  = 16'(MAX_STEPS);
  localparam logic [7:0]  SET_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  MAX_T  = 4'(MAX_TURNS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SENSE,
    S_DECIDE,
    S_ACT,
    S_SETTLE,
    S_MAP,
`ifdef SEQ_PAUSE_EN
    S_PAUSED,
`endif
    S_DONE,
    S_STUCK
  } state_t;

  state_t      state;
  logic        head_q;
  logic        left_q;
  logic        under_q;
  logic        bar_q;
  logic [3:0]  turns;
  logic [3:0]  turns_nx;
  logic [7:0]  settle_cnt;
  logic [15:0] step_nx;
  logic        dec_a;
  logic        dec_g;
  logic        dec_r;
  logic        to_stuck;

  // Left-hand rule never turns twice in a row into an open side.
  always_comb begin
    dec_a = 1'b0;
    dec_g = 1'b0;
    dec_r = 1'b0;
    if (under_q) begin
      dec_r = 1'b1;
    end else if (head_q && bar_q) begin
      dec_r = 1'b1;
    end else if (!head_q && !left_q) begin
      dec_a = girar;
      dec_g = !girar;
    end else if (!head_q) begin
      dec_a = 1'b1;
    end else begin
      dec_g = 1'b1;
    end
  end

  always_comb begin
    turns_nx = turns;
    if (dec_g) begin
      turns_nx = turns + 4'd1;
    end else if (dec_a) begin
      turns_nx = 4'd0;
    end
  end

  assign to_stuck = dec_g && (turns_nx == MAX_T);
  assign step_nx  = step_count + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      head_q     <= 1'b0;
      left_q     <= 1'b0;
      under_q    <= 1'b0;
      bar_q      <= 1'b0;
      turns      <= 4'd0;
      settle_cnt <= 8'd0;
      step_count <= 16'd0;
      sense_en   <= 1'b0;
      orient_en  <= 1'b0;
      move_en    <= 1'b0;
      map_en     <= 1'b0;
      avancar    <= 1'b0;
      girar      <= 1'b0;
      remover    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      sense_en  <= 1'b0;
      orient_en <= 1'b0;
      move_en   <= 1'b0;
      map_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SENSE;
            sense_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SENSE: begin
          head_q  <= head;
          left_q  <= left;
          under_q <= under;
          bar_q   <= barreira;
          state   <= S_DECIDE;
        end
        S_DECIDE: begin
          turns <= turns_nx;
          if (to_stuck) begin
            state   <= S_STUCK;
            stuck   <= 1'b1;
            busy    <= 1'b0;
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
          end else begin
            state     <= S_ACT;
            avancar   <= dec_a;
            girar     <= dec_g;
            remover   <= dec_r;
            orient_en <= dec_g;
            move_en   <= dec_a | dec_r;
          end
        end
        S_ACT: begin
          settle_cnt <= SET_LD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state  <= S_MAP;
            map_en <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_MAP: begin
          step_count <= step_nx;
          if (step_nx == MAX_S) begin
            state   <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
`ifdef SEQ_PAUSE_EN
          end else if (pause) begin
            state <= S_PAUSED;
            busy  <= 1'b0;
`endif
          end else begin
            state    <= S_SENSE;
            sense_en <= 1'b1;
          end
        end
`ifdef SEQ_PAUSE_EN
        S_PAUSED: begin
          if (!pause) begin
            state    <= S_SENSE;
            sense_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
`endif
        S_DONE: state <= S_DONE;
        S_STUCK: state <= S_STUCK;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
